// File: rtl/gpu_raster_pkg.sv
// Shared types and constants for the edge rasterizer: FSM state encoding,
// vertex layout and default grid geometry.
package gpu_raster_pkg;

  localparam int GRID_W       = 64;
  localparam int GRID_H       = 64;
  localparam int COORD_W      = 8;
  localparam int EDGE_CNT_TRI = 3;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SETUP,
    STEP,
    DONE
  } raster_state_t;

  // x sits in the low half so a 2*COORD_W slice of the coordinate bus maps directly
  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } vertex_t;

endpackage

// File: rtl/edge_raster_block_if.sv
// Start/vertex inputs and bitmap/status outputs of the edge rasterizer.
interface edge_raster_block_if #(
  parameter int GRID_W  = 64,
  parameter int GRID_H  = 64,
  parameter int COORD_W = 8
);

  logic                      raster_en;
  logic                      fill_type;
  logic [6*COORD_W-1:0]      coordinates;
  logic [GRID_W*GRID_H-1:0]  line_buffer;
  logic                      busy;
  logic                      raster_done;

  modport master (
    output raster_en, fill_type, coordinates,
    input  line_buffer, busy, raster_done
  );

  modport slave (
    input  raster_en, fill_type, coordinates,
    output line_buffer, busy, raster_done
  );

endinterface

// File: rtl/bresenham_stepper.sv
// Integer Bresenham walker: load latches one edge, each advance moves one pixel
// toward the end point until at_end_o rises.
module bresenham_stepper #(
  parameter int COORD_W = 8
) (
  input  logic               clk,
  input  logic               load_i,
  input  logic               advance_i,
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] y0_i,
  input  logic [COORD_W-1:0] x1_i,
  input  logic [COORD_W-1:0] y1_i,
  output logic [COORD_W-1:0] cur_x_o,
  output logic [COORD_W-1:0] cur_y_o,
  output logic               at_end_o
);

  localparam int DX_W  = COORD_W + 1;
  localparam int DY_W  = COORD_W + 2;
  localparam int ERR_W = COORD_W + 3;
  localparam int E2_W  = COORD_W + 4;

  function automatic logic [DX_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    return (a >= b) ? DX_W'(a - b) : DX_W'(b - a);
  endfunction

  logic [COORD_W-1:0]      x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0]      x1_q, x1_d, y1_q, y1_d;
  logic [DX_W-1:0]         dx_q, dx_d, dx_ld;
  logic signed [DY_W-1:0]  dy_q, dy_d, dy_ld;
  logic signed [ERR_W-1:0] err_q, err_d;
  logic                    sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic signed [E2_W-1:0]  e2, dy_e2, dx_e2;
  logic                    step_x, step_y, at_end;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    x1_d     = x1_q;
    y1_d     = y1_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    err_d    = err_q;
    sx_neg_d = sx_neg_q;
    sy_neg_d = sy_neg_q;

    at_end = (x_q == x1_q) && (y_q == y1_q);
    dx_ld  = abs_diff(x0_i, x1_i);
    dy_ld  = -$signed({1'b0, abs_diff(y0_i, y1_i)});

    // Both decisions look at the pre-update error term
    e2     = {err_q, 1'b0};
    dy_e2  = E2_W'(dy_q);
    dx_e2  = $signed(E2_W'(dx_q));
    step_x = (e2 >= dy_e2);
    step_y = (e2 <= dx_e2);

    if (load_i) begin
      x_d      = x0_i;
      y_d      = y0_i;
      x1_d     = x1_i;
      y1_d     = y1_i;
      dx_d     = dx_ld;
      dy_d     = dy_ld;
      err_d    = $signed({2'b00, dx_ld}) + ERR_W'(dy_ld);
      sx_neg_d = !(x0_i < x1_i);
      sy_neg_d = !(y0_i < y1_i);
    end else if (advance_i && !at_end) begin
      if (step_x) begin
        err_d = err_d + ERR_W'(dy_q);
        x_d   = sx_neg_q ? x_q - 1'b1 : x_q + 1'b1;
      end
      if (step_y) begin
        err_d = err_d + $signed({2'b00, dx_q});
        y_d   = sy_neg_q ? y_q - 1'b1 : y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    x_q      <= x_d;
    y_q      <= y_d;
    x1_q     <= x1_d;
    y1_q     <= y1_d;
    dx_q     <= dx_d;
    dy_q     <= dy_d;
    err_q    <= err_d;
    sx_neg_q <= sx_neg_d;
    sy_neg_q <= sy_neg_d;
  end

  assign cur_x_o  = x_q;
  assign cur_y_o  = y_q;
  assign at_end_o = at_end;

endmodule

// File: rtl/edge_raster_block.sv
// Rasterizes a triangle outline or a single line into a one-bit edge bitmap,
// one pixel per clock, holding the result until the next accepted start.
module edge_raster_block
  import gpu_raster_pkg::raster_state_t, gpu_raster_pkg::vertex_t,
         gpu_raster_pkg::EDGE_CNT_TRI, gpu_raster_pkg::IDLE, gpu_raster_pkg::CLEAR,
         gpu_raster_pkg::SETUP, gpu_raster_pkg::STEP, gpu_raster_pkg::DONE;
#(
  parameter int GRID_W  = gpu_raster_pkg::GRID_W,
  parameter int GRID_H  = gpu_raster_pkg::GRID_H,
  parameter int COORD_W = gpu_raster_pkg::COORD_W
) (
  input  logic              clk,
  input  logic              n_rst,
  edge_raster_block_if.slave rb_if
);

  localparam int NPIX  = GRID_W * GRID_H;
  localparam int IDX_W = $clog2(NPIX);
  localparam logic [COORD_W:0] GRID_W_C  = (COORD_W+1)'(GRID_W);
  localparam logic [COORD_W:0] GRID_H_C  = (COORD_W+1)'(GRID_H);
  localparam logic [1:0]       LAST_EDGE = 2'(EDGE_CNT_TRI - 1);

  raster_state_t      state_q, state_d;
  logic [1:0]         edge_idx_q, edge_idx_d;
  logic [NPIX-1:0]    line_buffer_q, line_buffer_d;
  vertex_t            vtx_q [3];
  logic               fill_type_q;
  vertex_t            ep0, ep1;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic               at_end, last_edge, in_grid;
  logic               busy, done, clear_buf, load, advance;
  logic [IDX_W-1:0]   pix_idx;

  // Inputs are captured only on acceptance; later changes are ignored
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && rb_if.raster_en) begin
      for (int i = 0; i < 3; i++) begin
        vtx_q[i] <= rb_if.coordinates[i*2*COORD_W +: 2*COORD_W];
      end
      fill_type_q <= rb_if.fill_type;
    end
  end

  always_comb begin
    ep0 = vtx_q[0];
    ep1 = vtx_q[1];
    case (edge_idx_q)
      2'd1: begin
        ep0 = vtx_q[1];
        ep1 = vtx_q[2];
      end
      2'd2: begin
        ep0 = vtx_q[2];
        ep1 = vtx_q[0];
      end
      default: ;
    endcase
  end

  bresenham_stepper #(.COORD_W(COORD_W)) u_stepper (
    .clk       (clk),
    .load_i    (load),
    .advance_i (advance),
    .x0_i      (ep0.x),
    .y0_i      (ep0.y),
    .x1_i      (ep1.x),
    .y1_i      (ep1.y),
    .cur_x_o   (cur_x),
    .cur_y_o   (cur_y),
    .at_end_o  (at_end)
  );

  assign last_edge = fill_type_q || (edge_idx_q == LAST_EDGE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rb_if.raster_en) state_d = CLEAR;
      CLEAR:   state_d = SETUP;
      SETUP:   state_d = STEP;
      STEP:    if (at_end) state_d = last_edge ? DONE : SETUP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == CLEAR) || (state_q == SETUP) || (state_q == STEP);
    done      = (state_q == DONE);
    clear_buf = (state_q == CLEAR);
    load      = (state_q == SETUP);
    advance   = (state_q == STEP);
  end

  // Off-grid pixels are dropped but the walk continues to the true end point
  always_comb begin
    in_grid       = ({1'b0, cur_x} < GRID_W_C) && ({1'b0, cur_y} < GRID_H_C);
    pix_idx       = IDX_W'(32'(cur_y) * GRID_W + 32'(cur_x));
    line_buffer_d = line_buffer_q;
    edge_idx_d    = edge_idx_q;
    if (clear_buf) begin
      line_buffer_d = '0;
      edge_idx_d    = '0;
    end else if (advance) begin
      if (in_grid) line_buffer_d[pix_idx] = 1'b1;
      if (at_end && !last_edge) edge_idx_d = edge_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      line_buffer_q <= '0;
      edge_idx_q    <= '0;
    end else begin
      line_buffer_q <= line_buffer_d;
      edge_idx_q    <= edge_idx_d;
    end
  end

  assign rb_if.line_buffer = line_buffer_q;
  assign rb_if.busy        = busy;
  assign rb_if.raster_done = done;

endmodule

// File: tb/tb_edge_raster_block.sv
// Bench for edge_raster_block: expected bitmaps and latencies are queued at
// each start and checked when raster_done arrives.
module tb_edge_raster_block;

  localparam int NPIX = 4096;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  edge_raster_block_if rb ();

  edge_raster_block dut (
    .clk   (clk),
    .n_rst (n_rst),
    .rb_if (rb)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NPIX-1:0] bm;
    int              lat;
  } exp_t;

  exp_t sb[$];

  function automatic logic [47:0] pk(input int ax, input int ay, input int bx,
                                     input int by, input int cx, input int cy);
    return {8'(cy), 8'(cx), 8'(by), 8'(bx), 8'(ay), 8'(ax)};
  endfunction

  function automatic logic [NPIX-1:0] bm_range(input int lo, input int hi);
    logic [NPIX-1:0] b;
    b = '0;
    for (int i = lo; i <= hi; i++) b[i] = 1'b1;
    return b;
  endfunction

  function automatic int first_diff(input logic [NPIX-1:0] a, input logic [NPIX-1:0] b);
    for (int i = 0; i < NPIX; i++) if (a[i] !== b[i]) return i;
    return -1;
  endfunction

  task automatic kick(input logic ft, input logic [47:0] c,
                      input logic [NPIX-1:0] bm, input int lat);
    exp_t e;
    e.bm  = bm;
    e.lat = lat;
    sb.push_back(e);
    rb.fill_type   = ft;
    rb.coordinates = c;
    rb.raster_en   = 1'b1;
  endtask

  // Runs from the acceptance edge to raster_done, then checks idle stability
  task automatic collect(input string nm, input int pulse_cyc, input int idle_cyc);
    exp_t e;
    int   cyc;
    int   busy_bad;
    @(posedge clk);
    #1;
    rb.raster_en = 1'b0;
    cyc      = 1;
    busy_bad = 0;
    while (rb.raster_done !== 1'b1 && cyc < 300) begin
      if (rb.busy !== 1'b1) busy_bad++;
      if (cyc == pulse_cyc) begin
        rb.raster_en   = 1'b1;
        rb.fill_type   = 1'b0;
        rb.coordinates = pk(0, 0, 40, 40, 0, 40);
      end else begin
        rb.raster_en = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    rb.raster_en = 1'b0;
    e = sb.pop_front();
    total++;
    if (cyc != e.lat) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", nm, cyc, e.lat);
    end
    total++;
    if (rb.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_at_done: got %b, expected 0", nm, rb.busy);
    end
    total++;
    if (busy_bad != 0) begin
      bad++;
      $display("FAIL %s busy_while_running: %0d low cycles, expected 0", nm, busy_bad);
    end
    total++;
    if (rb.line_buffer !== e.bm) begin
      bad++;
      $display("FAIL %s bitmap: got %0d set bits, expected %0d, first differing bit %0d",
               nm, $countones(rb.line_buffer), $countones(e.bm),
               first_diff(rb.line_buffer, e.bm));
    end
    for (int i = 0; i < idle_cyc; i++) begin
      rb.coordinates = 48'({$urandom(), $urandom()});
      rb.fill_type   = 1'($urandom());
      @(posedge clk);
      #1;
      total++;
      if (rb.line_buffer !== e.bm || rb.busy !== 1'b0 || rb.raster_done !== 1'b0) begin
        bad++;
        $display("FAIL %s idle_hold[%0d]: busy=%b done=%b bits=%0d, expected busy=0 done=0 bits=%0d",
                 nm, i, rb.busy, rb.raster_done, $countones(rb.line_buffer), $countones(e.bm));
      end
    end
  endtask

  task automatic test_reset();
    rb.raster_en   = 1'b0;
    rb.fill_type   = 1'b0;
    rb.coordinates = '0;
    n_rst          = 1'b0;
    #12;
    total++;
    if (rb.line_buffer !== '0) begin
      bad++;
      $display("FAIL reset_buffer: got %0d set bits, expected 0", $countones(rb.line_buffer));
    end
    total++;
    if (rb.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b, expected 0", rb.busy);
    end
    total++;
    if (rb.raster_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_done: got %b, expected 0", rb.raster_done);
    end
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_hline();
    kick(1'b1, pk(2, 5, 9, 5, 0, 0), bm_range(322, 329), 11);
    collect("hline", 0, 3);
  endtask

  task automatic test_triangle();
    logic [NPIX-1:0] b;
    int tb_bits[9] = '{0, 1, 2, 3, 64, 66, 128, 129, 192};
    b = '0;
    foreach (tb_bits[i]) b[tb_bits[i]] = 1'b1;
    kick(1'b0, pk(0, 0, 3, 0, 0, 3), b, 17);
    collect("triangle", 0, 3);
  endtask

  task automatic test_clip();
    kick(1'b1, pk(60, 10, 70, 10, 0, 0), bm_range(700, 703), 14);
    collect("clip", 0, 3);
  endtask

  task automatic test_degenerate();
    logic [NPIX-1:0] b;
    b = '0;
    b[65]  = 1'b1;
    b[129] = 1'b1;
    kick(1'b1, pk(7, 7, 7, 7, 0, 0), bm_range(455, 455), 4);
    collect("point", 0, 0);
    // Start held through the DONE cycle: ignored there, accepted one cycle later
    kick(1'b1, pk(1, 1, 1, 2, 0, 0), b, 5);
    @(posedge clk);
    #1;
    total++;
    if (rb.busy !== 1'b0 || rb.raster_done !== 1'b0) begin
      bad++;
      $display("FAIL done_cycle_start: busy=%b done=%b, expected busy=0 done=0",
               rb.busy, rb.raster_done);
    end
    collect("vline_after_point", 0, 3);
  endtask

  task automatic test_busy_ignore();
    kick(1'b1, pk(2, 5, 9, 5, 0, 0), bm_range(322, 329), 11);
    collect("busy_ignore", 5, 4);
  endtask

  task automatic test_reset_mid();
    rb.fill_type   = 1'b0;
    rb.coordinates = pk(0, 0, 3, 0, 0, 3);
    rb.raster_en   = 1'b1;
    @(posedge clk);
    #1;
    rb.raster_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (rb.line_buffer[3:0] !== 4'b0111 || rb.busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_progress: low bits=%b busy=%b, expected 0111 busy=1",
               rb.line_buffer[3:0], rb.busy);
    end
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if (rb.line_buffer !== '0 || rb.busy !== 1'b0 || rb.raster_done !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: bits=%0d busy=%b done=%b, expected 0 0 0",
               $countones(rb.line_buffer), rb.busy, rb.raster_done);
    end
    #3;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
    kick(1'b1, pk(2, 5, 9, 5, 0, 0), bm_range(322, 329), 11);
    collect("after_reset", 0, 3);
  endtask

  initial begin
    test_reset();
    test_hline();
    test_triangle();
    test_clip();
    test_degenerate();
    test_busy_ignore();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
